fetch_0: RTL and testbench

Instruction-fetch stage that sits directly upstream of the instruction memory and the F/D pipeline register. It owns the program counter and drives the memory's `address`, `access_size`, `rw` and `data_in` inputs. It produces the PC and valid tag that travel alongside `FD_IR`, so decode sees an {instruction, PC, valid} triple. It handles decode stalls and MIPS branch delay slots, and halts on fatal fetch errors.

---
 rtl/fetch_0_if.sv | 27 ++
 rtl/fetch_0.sv | 104 ++++++++++
 tb/tb_fetch_0.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_0_if.sv
// Fetch-stage bus: instruction-memory request side plus the decode-facing
// control inputs and the F/D tag outputs.
interface fetch_0_if;
    logic [31:0] address;
    logic [1:0]  access_size;
    logic        rw;
    logic [31:0] data_in;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        halt_req;
    logic [31:0] FD_PC;
    logic        FD_valid;
    logic [31:0] fetch_count;
    logic        fetch_err;

    modport master (
        input  stall, redirect, redirect_target, halt_req,
        output address, access_size, rw, data_in,
               FD_PC, FD_valid, fetch_count, fetch_err
    );
    modport slave (
        output stall, redirect, redirect_target, halt_req,
        input  address, access_size, rw, data_in,
               FD_PC, FD_valid, fetch_count, fetch_err
    );
endinterface

// File: rtl/fetch_0.sv
// Instruction-fetch stage: owns the PC, handles decode stalls, delay-slot
// redirects and halts on misaligned/out-of-range fetch targets.
`ifndef ADDR_START
`define ADDR_START 32'h0040_0000
`endif
`ifndef MEM_DEPTH
`define MEM_DEPTH 32'h0010_0000
`endif

module fetch_0 #(
    parameter logic [31:0] RESET_PC   = `ADDR_START,
    parameter logic [31:0] ADDR_LIMIT = `ADDR_START + `MEM_DEPTH - 32'd3
) (
    input  logic       clk,
    input  logic       rst_n,
    fetch_0_if.master  bus
);
    typedef enum logic {RUN, HALT} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] fd_pc, fd_pc_nxt;
    logic [31:0] cnt, cnt_nxt;
    logic [31:0] pend, pend_nxt;
    logic        pend_v, pend_v_nxt;
    logic        fd_valid, fd_valid_nxt;
    logic        err, err_nxt;
    logic [31:0] target;
    logic        bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            pc       <= RESET_PC;
            fd_pc    <= '0;
            fd_valid <= 1'b0;
            cnt      <= '0;
            err      <= 1'b0;
            pend     <= '0;
            pend_v   <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            fd_pc    <= fd_pc_nxt;
            fd_valid <= fd_valid_nxt;
            cnt      <= cnt_nxt;
            err      <= err_nxt;
            pend     <= pend_nxt;
            pend_v   <= pend_v_nxt;
        end
    end

    // A fresh redirect beats a held one; the held one beats sequential flow.
    assign target = bus.redirect ? bus.redirect_target :
                    pend_v       ? pend : pc + 32'd4;
    assign bad    = (target[1:0] != 2'b00) || (target >= ADDR_LIMIT);

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        fd_pc_nxt    = fd_pc;
        fd_valid_nxt = fd_valid;
        cnt_nxt      = cnt;
        err_nxt      = err;
        pend_nxt     = pend;
        pend_v_nxt   = pend_v;
        case (state)
            RUN: begin
                if (bus.halt_req) begin
                    state_nxt = HALT;
                end else if (bus.stall) begin
                    // Hold the target so the delay slot is fetched first on release.
                    if (bus.redirect) begin
                        pend_v_nxt = 1'b1;
                        pend_nxt   = bus.redirect_target;
                    end
                end else begin
                    fd_pc_nxt    = pc;
                    fd_valid_nxt = 1'b1;
                    cnt_nxt      = cnt + 32'd1;
                    if (!bus.redirect) pend_v_nxt = 1'b0;
                    if (bad) begin
                        err_nxt   = 1'b1;
                        state_nxt = HALT;
                    end else begin
                        pc_nxt = target;
                    end
                end
            end
            HALT: fd_valid_nxt = 1'b0;
            default: state_nxt = HALT;
        endcase
    end

    // Outside a fetch, re-read FD_PC so FD_IR stays put; reset is a non-fetch.
    assign bus.address     = (rst_n && state == RUN && !bus.stall) ? pc : fd_pc;
    assign bus.access_size = 2'b10;
    assign bus.rw          = 1'b1;
    assign bus.data_in     = 32'd0;
    assign bus.FD_PC       = fd_pc;
    assign bus.FD_valid    = fd_valid;
    assign bus.fetch_count = cnt;
    assign bus.fetch_err   = err;
endmodule

// File: tb/tb_fetch_0.sv
// Bench for fetch_0: directed scenarios followed by random stall/redirect/halt
// traffic, all compared against a transaction-level reference model.
module tb_fetch_0;
    localparam logic [31:0] RPC = 32'h0040_0000;
    localparam logic [31:0] LIM = 32'h004F_FFFD;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    fetch_0_if bus();

    fetch_0 dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Reference model state: what decode should observe, in program terms.
    logic [31:0] m_pc, m_fdpc, m_cnt, m_pend;
    logic        m_valid, m_err, m_halt, m_pv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic is_bad(input logic [31:0] a);
        return (a % 4 != 0) || (a >= LIM);
    endfunction

    task automatic model_reset();
        m_pc = RPC; m_fdpc = 0; m_cnt = 0; m_pend = 0;
        m_valid = 0; m_err = 0; m_halt = 0; m_pv = 0;
    endtask

    task automatic model_edge(input logic s, input logic r, input logic [31:0] t, input logic h);
        logic [31:0] nxt;
        if (m_halt) begin
            m_valid = 0;
        end else if (h) begin
            m_halt = 1;
        end else if (s) begin
            if (r) begin m_pend = t; m_pv = 1; end
        end else begin
            if (r)         nxt = t;
            else if (m_pv) begin nxt = m_pend; m_pv = 0; end
            else           nxt = m_pc + 4;
            m_fdpc = m_pc; m_valid = 1; m_cnt = m_cnt + 1;
            if (is_bad(nxt)) begin m_err = 1; m_halt = 1; end
            else m_pc = nxt;
        end
    endtask

    task automatic check_regs();
        chk("FD_PC", bus.FD_PC, m_fdpc);
        chk("FD_valid", {31'd0, bus.FD_valid}, {31'd0, m_valid});
        chk("fetch_count", bus.fetch_count, m_cnt);
        chk("fetch_err", {31'd0, bus.fetch_err}, {31'd0, m_err});
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic step(input logic s, input logic r, input logic [31:0] t, input logic h);
        bus.stall = s; bus.redirect = r; bus.redirect_target = t; bus.halt_req = h;
        #1;
        chk("address", bus.address, (!m_halt && !s) ? m_pc : m_fdpc);
        @(posedge clk);
        model_edge(s, r, t, h);
        #1;
        check_regs();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_address", bus.address, 32'd0);
        check_regs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.stall = 0; bus.redirect = 0; bus.redirect_target = 0; bus.halt_req = 0;
        model_reset();
        #2;
        chk("rst_address", bus.address, 32'd0);
        check_regs();
        chk("access_size", {30'd0, bus.access_size}, 32'd2);
        chk("rw", {31'd0, bus.rw}, 32'd1);
        chk("data_in", bus.data_in, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Sequential fetch
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        chk("seq_fdpc", bus.FD_PC, RPC + 12);
        chk("seq_cnt", bus.fetch_count, 32'd4);

        // Stall hold
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
        chk("stall_cnt", bus.fetch_count, 32'd4);
        chk("stall_addr", bus.address, RPC + 12);
        step(0, 0, 0, 0);
        chk("post_stall", bus.FD_PC, RPC + 16);

        // Redirect in RUN: delay slot P, then target, then target+4
        step(0, 1, 32'h0040_0100, 0);
        chk("rd_slot", bus.FD_PC, RPC + 20);
        step(0, 0, 0, 0);
        chk("rd_tgt", bus.FD_PC, 32'h0040_0100);
        step(0, 0, 0, 0);
        chk("rd_tgt4", bus.FD_PC, 32'h0040_0104);

        // Redirect during stall: P=0x00400108, T=0x00400200
        step(1, 1, 32'h0040_0200, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("srd_slot", bus.FD_PC, 32'h0040_0108);
        step(0, 0, 0, 0);
        chk("srd_tgt", bus.FD_PC, 32'h0040_0200);

        // Boundary: sequential step past the last in-range word faults
        step(0, 1, 32'h004F_FFF8, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("lim_fdpc", bus.FD_PC, 32'h004F_FFFC);
        chk("lim_err", {31'd0, bus.fetch_err}, 32'd1);
        step(0, 0, 0, 0);
        chk("lim_valid", {31'd0, bus.FD_valid}, 32'd0);
        do_reset();

        // Misaligned redirect fault, then HALT ignores stall/redirect
        step(0, 0, 0, 0);
        step(0, 1, RPC + 2, 0);
        chk("fault_err", {31'd0, bus.fetch_err}, 32'd1);
        step(1, 1, RPC + 8, 0);
        chk("fault_valid", {31'd0, bus.FD_valid}, 32'd0);
        step(0, 1, RPC + 16, 0);
        step(0, 0, 0, 0);
        chk("fault_cnt", bus.fetch_count, 32'd2);
        chk("fault_fdpc", bus.FD_PC, RPC + 4);
        do_reset();

        // Reset with a pending redirect and count 7
        for (int i = 0; i < 7; i++) step(0, 0, 0, 0);
        step(1, 1, 32'h0040_0300, 0);
        chk("pre_rst_cnt", bus.fetch_count, 32'd7);
        do_reset();
        step(0, 0, 0, 0);
        chk("post_rst", bus.FD_PC, RPC);
        step(0, 0, 0, 0);
        chk("post_rst2", bus.FD_PC, RPC + 4);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic s, r, h;
            logic [31:0] t;
            int pick;
            s = ($urandom_range(0, 3) == 0);
            h = ($urandom_range(0, 99) == 0);
            r = ($urandom_range(0, 4) == 0) && !(m_pv && !s);
            pick = $urandom_range(0, 24);
            if (pick == 0)      t = $urandom;
            else if (pick == 1) t = 32'h004F_FFF0 + ($urandom_range(0, 3) << 2);
            else                t = RPC + ($urandom_range(0, 32'h3FFFF) << 2);
            if (m_halt) begin
                step(s, 1'b1, t, h);
                do_reset();
            end else begin
                step(s, r, t, h);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
